ttl_74166_multi_sync: RTL and testbench

//  Parametrised multi-plane parallel-load shift register, 74LS166-style, fully synchronous to clk.

---
 rtl/ttl_74166_multi_sync.sv | 94 +++++++++
 tb/tb_ttl_74166_multi_sync.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ttl_74166_multi_sync.sv
// Multi-plane 74LS166-style parallel-load shift register, fully synchronous to clk.
// Planes shift in lockstep; direction latched at load; tracks bits remaining and pulses on word end.
module ttl_74166_multi_sync #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PLANES   = 4,
    parameter int unsigned EDGE_DET = 1
) (
    input  logic                          clk,
    input  logic                          Reset_n,
    input  logic                          CLRn,
    input  logic                          cen,
    input  logic                          INH,
    input  logic                          SH_LDn,
    input  logic                          FLIP,
    input  logic [PLANES-1:0]             SER,
    input  logic [PLANES*WIDTH-1:0]       D,
    output logic [PLANES-1:0]             Q,
    output logic [$clog2(WIDTH+1)-1:0]    CNT,
    output logic                          EMPTY,
    output logic                          LD_REQ
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [PLANES-1:0][WIDTH-1:0] sr_q, sr_d;
    logic                         flip_q, flip_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         ld_req_q, ld_req_d;
    logic                         ck_q, ck_d;
    logic                         ck;
    logic                         evt;

    // TTL clock pin is cen OR INH, so an INH rise with cen low is a real edge.
    assign ck  = cen | INH;
    assign evt = (EDGE_DET != 0) ? (ck & ~ck_q) : (cen & ~INH);

    always_ff @(posedge clk) begin
        sr_q     <= sr_d;
        flip_q   <= flip_d;
        cnt_q    <= cnt_d;
        ld_req_q <= ld_req_d;
        ck_q     <= ck_d;
    end

    always_comb begin
        sr_d     = sr_q;
        flip_d   = flip_q;
        cnt_d    = cnt_q;
        ld_req_d = 1'b0;
        ck_d     = ck;
        if (!Reset_n) begin
            sr_d   = '0;
            flip_d = 1'b0;
            cnt_d  = '0;
            // Start high so a cen already asserted at release is not seen as an edge.
            ck_d   = 1'b1;
        end else if (!CLRn) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (evt) begin
            if (!SH_LDn) begin
                for (int p = 0; p < int'(PLANES); p++) begin
                    sr_d[p] = D[p*WIDTH +: WIDTH];
                end
                flip_d = FLIP;
                cnt_d  = CW'(WIDTH);
            end else begin
                for (int p = 0; p < int'(PLANES); p++) begin
                    if (flip_q) begin
                        sr_d[p] = {SER[p], sr_q[p][WIDTH-1:1]};
                    end else begin
                        sr_d[p] = {sr_q[p][WIDTH-2:0], SER[p]};
                    end
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
                ld_req_d = (cnt_q == CW'(1));
            end
        end
    end

    always_comb begin
        Q = '0;
        for (int p = 0; p < int'(PLANES); p++) begin
            Q[p] = flip_q ? sr_q[p][0] : sr_q[p][WIDTH-1];
        end
    end

    assign CNT    = cnt_q;
    assign EMPTY  = (cnt_q == '0);
    assign LD_REQ = ld_req_q;

endmodule

// File: tb/tb_ttl_74166_multi_sync.sv
// Directed bench for ttl_74166_multi_sync: edge-detect instance plus a strobe-mode instance.
module tb_ttl_74166_multi_sync;

    localparam int unsigned W = 8;
    localparam int unsigned P = 2;

    logic         clk = 1'b0;
    logic         Reset_n, CLRn, cen, cen0, INH, SH_LDn, FLIP;
    logic [P-1:0] SER;
    logic [P*W-1:0] D;
    logic [P-1:0] Q, Q0;
    logic [3:0]   CNT, CNT0;
    logic         EMPTY, EMPTY0, LD_REQ, LD_REQ0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ttl_74166_multi_sync #(.WIDTH(W), .PLANES(P), .EDGE_DET(1)) u_dut (
        .clk(clk), .Reset_n(Reset_n), .CLRn(CLRn), .cen(cen), .INH(INH), .SH_LDn(SH_LDn),
        .FLIP(FLIP), .SER(SER), .D(D), .Q(Q), .CNT(CNT), .EMPTY(EMPTY), .LD_REQ(LD_REQ)
    );

    ttl_74166_multi_sync #(.WIDTH(W), .PLANES(P), .EDGE_DET(0)) u_dut_strobe (
        .clk(clk), .Reset_n(Reset_n), .CLRn(CLRn), .cen(cen0), .INH(INH), .SH_LDn(SH_LDn),
        .FLIP(FLIP), .SER(SER), .D(D), .Q(Q0), .CNT(CNT0), .EMPTY(EMPTY0), .LD_REQ(LD_REQ0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One emulated shift clock: a low clk then a high clk; the event lands on the high one.
    task automatic pulse();
        cen = 1'b0;
        step();
        check("ldreq_idle", 32'(LD_REQ), 32'd0);
        cen = 1'b1;
        step();
    endtask

    task automatic load(input logic [P*W-1:0] data, input logic flip);
        SH_LDn = 1'b0;
        D      = data;
        FLIP   = flip;
        pulse();
        SH_LDn = 1'b1;
    endtask

    // s1/s0 hold the expected Q sequence per plane, first bit in the MSB position.
    task automatic run_word(input logic [7:0] s1, input logic [7:0] s0, input logic flip_mid);
        for (int i = 0; i < 8; i++) begin
            check("word_q", 32'(Q), 32'({s1[7-i], s0[7-i]}));
            check("word_cnt", 32'(CNT), 32'(8 - i));
            check("word_ldreq", 32'(LD_REQ), 32'd0);
            if (i == 3) FLIP = flip_mid;
            pulse();
        end
        check("end_cnt", 32'(CNT), 32'd0);
        check("end_empty", 32'(EMPTY), 32'd1);
        check("end_ldreq", 32'(LD_REQ), 32'd1);
        step();
        check("end_ldreq_off", 32'(LD_REQ), 32'd0);
    endtask

    initial begin
        Reset_n = 1'b0; CLRn = 1'b1; cen = 1'b1; cen0 = 1'b0; INH = 1'b0;
        SH_LDn = 1'b1; FLIP = 1'b0; SER = '0; D = '0;

        // 1: reset with cen high; release with cen high must not fire
        repeat (3) step();
        check("rst_q", 32'(Q), 32'd0);
        check("rst_cnt", 32'(CNT), 32'd0);
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_ldreq", 32'(LD_REQ), 32'd0);
        Reset_n = 1'b1;
        SH_LDn  = 1'b0;
        D       = 16'hC10F;
        repeat (2) step();
        check("rel_no_evt", 32'(CNT), 32'd0);
        pulse();
        check("rel_first_evt", 32'(CNT), 32'd8);
        SH_LDn = 1'b1;

        // 2: MSB first
        load(16'hC10F, 1'b0);
        SER = 2'b00;
        run_word(8'b11000001, 8'b00001111, 1'b1);

        // 3: LSB first; FLIP dropped mid-word must not matter
        load(16'hC10F, 1'b1);
        run_word(8'b10000011, 8'b11110000, 1'b0);

        // 4: inhibit
        load(16'hC10F, 1'b0);
        pulse();
        check("inh_pre_cnt", 32'(CNT), 32'd7);
        INH = 1'b1;
        repeat (3) pulse();
        check("inh_cnt", 32'(CNT), 32'd7);
        check("inh_q", 32'(Q), 32'b10);
        INH = 1'b0;
        step();
        cen = 1'b0;
        step();
        check("inh_low_cnt", 32'(CNT), 32'd7);
        INH = 1'b1;
        step();
        check("inh_rise_cnt", 32'(CNT), 32'd6);
        step();
        check("inh_rise_once", 32'(CNT), 32'd6);
        INH = 1'b0;

        // 5: clear coincident with a load edge
        SH_LDn = 1'b0;
        D      = 16'hFFFF;
        cen    = 1'b0;
        step();
        CLRn = 1'b0;
        cen  = 1'b1;
        step();
        check("clr_q", 32'(Q), 32'd0);
        check("clr_cnt", 32'(CNT), 32'd0);
        check("clr_empty", 32'(EMPTY), 32'd1);
        check("clr_ldreq", 32'(LD_REQ), 32'd0);
        CLRn = 1'b1;
        step();
        check("clr_no_late_evt", 32'(CNT), 32'd0);
        SH_LDn = 1'b1;
        load(16'hC10F, 1'b0);
        check("clr_reload_cnt", 32'(CNT), 32'd8);
        check("clr_reload_q", 32'(Q), 32'b10);

        // 6: zero word with SER high flowing through, CNT saturating
        load(16'h0000, 1'b0);
        SER = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            pulse();
            check("sat_q", 32'(Q), (k >= 8) ? 32'b11 : 32'b00);
            check("sat_cnt", 32'(CNT), (k >= 8) ? 32'd0 : 32'(8 - k));
            check("sat_ldreq", 32'(LD_REQ), (k == 8) ? 32'd1 : 32'd0);
        end
        SER = 2'b00;

        // 6b: strobe mode, cen held high 4 clks
        SH_LDn = 1'b0;
        D      = 16'hC10F;
        FLIP   = 1'b0;
        cen0   = 1'b1;
        step();
        check("stb_load_cnt", 32'(CNT0), 32'd8);
        SH_LDn = 1'b1;
        repeat (4) step();
        cen0 = 1'b0;
        check("stb_cnt", 32'(CNT0), 32'd4);
        check("stb_q", 32'(Q0), 32'b01);
        step();
        check("stb_hold", 32'(CNT0), 32'd4);
        cen0 = 1'b1;
        INH  = 1'b1;
        step();
        check("stb_inh", 32'(CNT0), 32'd4);
        cen0 = 1'b0;
        INH  = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
